bitstream_decoder: RTL

- Stochastic-to-binary converter: the inverse of the weight/value bitstream generator.
- Counts ones in a unipolar bitstream over a fixed window of 2^WINDOW_LOG2 valid samples.
- Returns the count as a binary value through a valid/ready handshake.
- Sits at network outputs (after neuron/sigmoid stages) so results can be read as integers by the bench or a host interface.

---
 rtl/bitstream_pkg.sv | 13 +
 rtl/bitstream_decoder_window_counter.sv | 34 +++
 rtl/bitstream_decoder.sv | 100 ++++++++++
 3 files changed

// File: rtl/bitstream_pkg.sv
// Shared types and sizing constants for the stochastic bitstream decoder and generator.
`timescale 1ns/1ps
package bitstream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } decoder_state_t;

    localparam int unsigned DEFAULT_WINDOW_LOG2 = 8;

endpackage

// File: rtl/bitstream_decoder_window_counter.sv
// Sample and ones counters for one decoding window; flags the final sample of the window.
`timescale 1ns/1ps
module window_counter
    import bitstream_pkg::*;
#(
    parameter int unsigned WINDOW_LOG2 = DEFAULT_WINDOW_LOG2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_i,
    input  logic                 en_i,
    input  logic                 bit_i,
    output logic                 last_sample_o,
    output logic [WINDOW_LOG2:0] next_ones_o
);

    logic [WINDOW_LOG2-1:0] sample_q;
    logic [WINDOW_LOG2:0]   ones_q;

    assign next_ones_o   = ones_q + {{WINDOW_LOG2{1'b0}}, bit_i};
    assign last_sample_o = en_i && (sample_q == '1);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            sample_q <= '0;
            ones_q   <= '0;
        end else if (en_i) begin
            sample_q <= sample_q + 1'b1;
            ones_q   <= next_ones_o;
        end
    end

endmodule

// File: rtl/bitstream_decoder.sv
// Stochastic-to-binary decoder: counts ones over 2^WINDOW_LOG2 valid samples, result via valid/ready.
// Define BITSTREAM_DECODER_BIPOLAR_EN for a signed 2*ones-N result instead of the unipolar count.
`timescale 1ns/1ps
module bitstream_decoder
    import bitstream_pkg::*;
#(
    parameter int unsigned WINDOW_LOG2 = DEFAULT_WINDOW_LOG2,
    parameter int unsigned OUT_WIDTH   = WINDOW_LOG2 + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    output logic                 busy,
    output logic [OUT_WIDTH-1:0] value_out,
    output logic                 out_valid,
    input  logic                 out_ready
);

    decoder_state_t         state_q;
    logic                   busy_q;
    logic                   out_valid_q;
    logic [OUT_WIDTH-1:0]   value_q;
    logic [OUT_WIDTH-1:0]   result_d;
    logic                   clear_d;
    logic                   count_en_d;
    logic                   last_sample;
    logic [WINDOW_LOG2:0]   next_ones;

    // A new window clears the counters on the start cycle, so a bit offered then is never counted.
    assign clear_d    = start && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign count_en_d = (state_q == COUNT) && bit_valid;

    window_counter #(
        .WINDOW_LOG2 (WINDOW_LOG2)
    ) u_window_counter (
        .clk           (clk),
        .rst           (rst),
        .clear_i       (clear_d),
        .en_i          (count_en_d),
        .bit_i         (bit_in),
        .last_sample_o (last_sample),
        .next_ones_o   (next_ones)
    );

`ifdef BITSTREAM_DECODER_BIPOLAR_EN
    localparam logic [OUT_WIDTH-1:0] N_EXT = OUT_WIDTH'(1) << WINDOW_LOG2;
    assign result_d = (OUT_WIDTH'(next_ones) << 1) - N_EXT;
`else
    assign result_d = OUT_WIDTH'(next_ones);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            value_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= COUNT;
                        busy_q  <= 1'b1;
                    end
                end
                COUNT: begin
                    if (last_sample) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        value_q     <= result_d;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (start) begin
                            state_q <= COUNT;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign value_out = value_q;

endmodule
